masked_conv_b2a_a2b: RTL and testbench

Parametrised first-order (2-share) masked conversion unit that runs either Boolean→arithmetic (B2A) or arithmetic→Boolean (A2B) conversion on one operand.

- Sits beside the masked bitwise/arith units of the masked ALU as a standalone multi-cycle functional unit with valid/ready handshakes on input and output.
- Internally it is an iterative DOM-protected Kogge-Stone Boolean adder/subtractor whose round count scales with `BIT_WIDTH`.
- Fresh randomness is consumed every busy cycle.

---
 rtl/masked_conv_b2a_a2b.sv | 208 ++++++++++++++++++++
 tb/tb_masked_conv_b2a_a2b.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/masked_conv_b2a_a2b.sv
// masked_conv_b2a_a2b: first-order (2-share) masked Boolean<->arithmetic
// conversion unit built around an iterative DOM-protected Kogge-Stone adder.
// Optional feature macro: MASKED_CONV_OUT_REFRESH_EN (refresh output shares
// with fresh randomness in FINAL).
module masked_conv_b2a_a2b #(
   parameter int BIT_WIDTH = 32
) (
   input  logic                   g_clk,
   input  logic                   g_resetn,
   input  logic                   flush,
   input  logic                   i_valid,
   output logic                   i_ready,
   input  logic                   i_op,
   input  logic [BIT_WIDTH-1:0]   i_x0,
   input  logic [BIT_WIDTH-1:0]   i_x1,
   input  logic [3*BIT_WIDTH-1:0] i_rnd,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic                   o_op,
   output logic [BIT_WIDTH-1:0]   o_r0,
   output logic [BIT_WIDTH-1:0]   o_r1
);

   localparam int W      = BIT_WIDTH;
   localparam int ROUNDS = $clog2(BIT_WIDTH);
   localparam int KW     = $clog2(ROUNDS);
   localparam logic [KW-1:0] LAST_K = KW'(ROUNDS - 1);
   localparam logic [KW-1:0] K_ZERO = {KW{1'b0}};
   localparam logic [KW-1:0] K_ONE  = {{(KW-1){1'b0}}, 1'b1};
   localparam logic [W-1:0]  ZERO_W = {W{1'b0}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INIT  = 3'd1,
      S_ROUND = 3'd2,
      S_FINAL = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // DOM-indep AND of two Boolean-shared words; r masks both cross terms,
   // so the recombined result is (x0^x1)&(y0^y1). Returns {z1, z0}.
   function automatic logic [2*BIT_WIDTH-1:0] dom_and(
      input logic [BIT_WIDTH-1:0] x0, input logic [BIT_WIDTH-1:0] x1,
      input logic [BIT_WIDTH-1:0] y0, input logic [BIT_WIDTH-1:0] y1,
      input logic [BIT_WIDTH-1:0] r);
      logic [BIT_WIDTH-1:0] z0;
      logic [BIT_WIDTH-1:0] z1;
      z0 = (x0 & y0) ^ ((x0 & y1) ^ r);
      z1 = (x1 & y1) ^ ((x1 & y0) ^ r);
      return {z1, z0};
   endfunction

   state_t         state_q, state_d;
   logic           op_q, op_d;
   logic [W-1:0]   a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
   logic [W-1:0]   g0_q, g0_d, g1_q, g1_d, p0_q, p0_d, p1_q, p1_d;
   logic [W-1:0]   po0_q, po0_d, po1_q, po1_d, gs_q, gs_d;
   logic [KW-1:0]  k_q, k_d;
   logic [W-1:0]   r0_q, r0_d, r1_q, r1_d;
   logic           oop_q, oop_d, ov_q, ov_d, rdy_q, rdy_d;

   logic [W-1:0]      b1_eff_s, p0_s, p1_s, cin_s, s0_s, s1_s, u_s;
   logic [2*W-1:0]    dom_g_s, dom_p_s;
   logic [ROUNDS-1:0] shamt_s;

   assign i_ready = rdy_q;
   assign o_valid = ov_q;
   assign o_op    = oop_q;
   assign o_r0    = r0_q;
   assign o_r1    = r1_q;

   // Next-state and datapath: flush dominates, otherwise the conversion FSM.
   always_comb begin
      state_d = state_q;  op_d  = op_q;
      a0_d = a0_q;  a1_d = a1_q;  b0_d = b0_q;  b1_d = b1_q;
      g0_d = g0_q;  g1_d = g1_q;  p0_d = p0_q;  p1_d = p1_q;
      po0_d = po0_q;  po1_d = po1_q;  gs_d = gs_q;  k_d = k_q;
      r0_d = r0_q;  r1_d = r1_q;  oop_d = oop_q;  ov_d = ov_q;  rdy_d = rdy_q;
      b1_eff_s = ZERO_W;  p0_s = ZERO_W;  p1_s = ZERO_W;  cin_s = ZERO_W;
      s0_s = ZERO_W;  s1_s = ZERO_W;  u_s = ZERO_W;
      dom_g_s = {(2*W){1'b0}};  dom_p_s = {(2*W){1'b0}};
      shamt_s = {{(ROUNDS-1){1'b0}}, 1'b1} << k_q;
      if (flush) begin
         state_d = S_IDLE;  op_d = 1'b0;
         a0_d = ZERO_W;  a1_d = ZERO_W;  b0_d = ZERO_W;  b1_d = ZERO_W;
         g0_d = ZERO_W;  g1_d = ZERO_W;  p0_d = ZERO_W;  p1_d = ZERO_W;
         po0_d = ZERO_W;  po1_d = ZERO_W;  gs_d = ZERO_W;  k_d = K_ZERO;
         r0_d = ZERO_W;  r1_d = ZERO_W;  oop_d = 1'b0;  ov_d = 1'b0;
         rdy_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               rdy_d = 1'b1;
               if (i_valid && rdy_q) begin
                  state_d = S_INIT;
                  rdy_d   = 1'b0;
                  op_d    = i_op;
                  a0_d    = i_x0;
                  if (i_op) begin
                     // A2B: a = x0, b = x1 re-shared with fresh mask m.
                     a1_d = ZERO_W;
                     b0_d = i_rnd[3*W-1:2*W];
                     b1_d = i_x1 ^ i_rnd[3*W-1:2*W];
                     gs_d = ZERO_W;
                  end else begin
                     // B2A: a = (x0,x1), b = (0,gs); gs kept to become r1.
                     a1_d = i_x1;
                     b0_d = ZERO_W;
                     b1_d = i_rnd[3*W-1:2*W];
                     gs_d = i_rnd[3*W-1:2*W];
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_INIT: begin
               // Subtraction: ~b on share 1 plus carry-in 1.
               b1_eff_s = op_q ? ~b1_q : b1_q;
               cin_s    = {{(W-1){1'b0}}, op_q};
               p0_s     = a0_q ^ b0_q;
               p1_s     = a1_q ^ b1_eff_s;
               dom_g_s  = dom_and(a0_q, a1_q, b0_q, b1_eff_s, i_rnd[W-1:0]);
               g0_d     = dom_g_s[W-1:0]   ^ (p0_s & cin_s);
               g1_d     = dom_g_s[2*W-1:W] ^ (p1_s & cin_s);
               p0_d     = p0_s;
               p1_d     = p1_s;
               // Carry into bit 0 is the carry-in itself; fold it into one share.
               po0_d    = p0_s ^ cin_s;
               po1_d    = p1_s;
               a0_d = ZERO_W;  a1_d = ZERO_W;  b0_d = ZERO_W;  b1_d = ZERO_W;
               k_d      = K_ZERO;
               state_d  = S_ROUND;
            end
            S_ROUND: begin
               dom_g_s = dom_and(p0_q, p1_q, g0_q << shamt_s, g1_q << shamt_s,
                                 i_rnd[W-1:0]);
               g0_d = g0_q ^ dom_g_s[W-1:0];
               g1_d = g1_q ^ dom_g_s[2*W-1:W];
               if (k_q == LAST_K) begin
                  p0_d = ZERO_W;  p1_d = ZERO_W;
                  k_d = K_ZERO;
                  state_d = S_FINAL;
               end else begin
                  dom_p_s = dom_and(p0_q, p1_q, p0_q << shamt_s, p1_q << shamt_s,
                                    i_rnd[2*W-1:W]);
                  p0_d = dom_p_s[W-1:0];
                  p1_d = dom_p_s[2*W-1:W];
                  k_d  = k_q + K_ONE;
               end
            end
            S_FINAL: begin
`ifdef MASKED_CONV_OUT_REFRESH_EN
               u_s = i_rnd[W-1:0];
`else
               u_s = ZERO_W;
`endif
               s0_s = po0_q ^ (g0_q << 1'b1);
               s1_s = po1_q ^ (g1_q << 1'b1);
               if (op_q) begin
                  r0_d = s0_s ^ u_s;
                  r1_d = s1_s ^ u_s;
               end else begin
                  // Only B2A recombines: s0^s1 = x + gs.
                  r0_d = (s0_s ^ s1_s) + u_s;
                  r1_d = gs_q + u_s;
               end
               oop_d = op_q;  ov_d = 1'b1;
               op_d = 1'b0;  gs_d = ZERO_W;
               g0_d = ZERO_W;  g1_d = ZERO_W;  po0_d = ZERO_W;  po1_d = ZERO_W;
               state_d = S_DONE;
            end
            S_DONE: begin
               if (o_ready) begin
                  r0_d = ZERO_W;  r1_d = ZERO_W;  oop_d = 1'b0;  ov_d = 1'b0;
                  rdy_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end
            default: begin
               state_d = S_IDLE;
               rdy_d   = 1'b0;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state_q <= S_IDLE;  op_q <= 1'b0;
         a0_q <= ZERO_W;  a1_q <= ZERO_W;  b0_q <= ZERO_W;  b1_q <= ZERO_W;
         g0_q <= ZERO_W;  g1_q <= ZERO_W;  p0_q <= ZERO_W;  p1_q <= ZERO_W;
         po0_q <= ZERO_W;  po1_q <= ZERO_W;  gs_q <= ZERO_W;  k_q <= K_ZERO;
         r0_q <= ZERO_W;  r1_q <= ZERO_W;  oop_q <= 1'b0;  ov_q <= 1'b0;
         rdy_q <= 1'b0;
      end else begin
         state_q <= state_d;  op_q <= op_d;
         a0_q <= a0_d;  a1_q <= a1_d;  b0_q <= b0_d;  b1_q <= b1_d;
         g0_q <= g0_d;  g1_q <= g1_d;  p0_q <= p0_d;  p1_q <= p1_d;
         po0_q <= po0_d;  po1_q <= po1_d;  gs_q <= gs_d;  k_q <= k_d;
         r0_q <= r0_d;  r1_q <= r1_d;  oop_q <= oop_d;  ov_q <= ov_d;
         rdy_q <= rdy_d;
      end
   end

endmodule

// File: tb/tb_masked_conv_b2a_a2b.sv
// Scoreboard bench for masked_conv_b2a_a2b (W = 32). Expected values come
// from plain arithmetic on the unmasked operands; a negedge monitor pops and
// compares whenever a result is handed over.
module tb_masked_conv_b2a_a2b;
   localparam int W = 32;

   logic           g_clk = 1'b0;
   logic           g_resetn, flush, i_valid, i_ready, i_op;
   logic           o_valid, o_ready, o_op;
   logic [W-1:0]   i_x0, i_x1, o_r0, o_r1;
   logic [3*W-1:0] i_rnd;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic         op;
      logic [W-1:0] x;
      logic [W-1:0] gs;
      time          t_acc;
   } exp_t;
   exp_t sbq[$];
   exp_t mon_e;

   bit           mon_en = 1'b0, rnd_zero = 1'b0, gs_fix_en = 1'b0, rand_ordy = 1'b0;
   logic [W-1:0] gs_fix = 32'h0;
   logic [W-1:0] prev_r0 = 32'h0, prev_r1 = 32'h0;
   bit           prev_v = 1'b0, prev_hs = 1'b0;

   masked_conv_b2a_a2b #(.BIT_WIDTH(W)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
      .i_valid(i_valid), .i_ready(i_ready), .i_op(i_op),
      .i_x0(i_x0), .i_x1(i_x1), .i_rnd(i_rnd),
      .o_valid(o_valid), .o_ready(o_ready), .o_op(o_op),
      .o_r0(o_r0), .o_r1(o_r1)
   );

   always #5 g_clk = ~g_clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Fresh randomness every cycle (optionally zero, optionally fixed gs/m).
   initial begin
      i_rnd = {$urandom(), $urandom(), $urandom()};
      forever begin
         @(posedge g_clk); #1;
         if (rnd_zero) i_rnd = {(3*W){1'b0}};
         else          i_rnd = {$urandom(), $urandom(), $urandom()};
         if (gs_fix_en) i_rnd[3*W-1:2*W] = gs_fix;
      end
   end

   // Random consumer backpressure during the random phase.
   initial begin
      forever begin
         @(posedge g_clk); #1;
         if (rand_ordy) o_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: output invariants, stability under backpressure, latency, scoreboard.
   always @(negedge g_clk) begin
      if (mon_en) begin
         if (prev_hs) chk("ready_after_handshake", {31'h0, i_ready}, 32'h1);
         if (!o_valid) begin
            chk("idle_r0", o_r0, 32'h0);
            chk("idle_r1", o_r1, 32'h0);
            chk("idle_op", {31'h0, o_op}, 32'h0);
         end else begin
            chk("busy_ready", {31'h0, i_ready}, 32'h0);
            if (prev_v && !prev_hs) begin
               chk("hold_r0", o_r0, prev_r0);
               chk("hold_r1", o_r1, prev_r1);
            end
            if (!prev_v) begin
               if (sbq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_output actual=valid required=no_result");
               end else begin
                  chk("latency", 32'($time - sbq[0].t_acc), 32'd75);
               end
            end
            if (o_ready && sbq.size() != 0) begin
               mon_e = sbq.pop_front();
               chk("op", {31'h0, o_op}, {31'h0, mon_e.op});
               if (mon_e.op) begin
                  chk("a2b_xor", o_r0 ^ o_r1, mon_e.x);
               end else begin
                  chk("b2a_diff", o_r0 - o_r1, mon_e.x);
`ifndef MASKED_CONV_OUT_REFRESH_EN
                  chk("b2a_r0", o_r0, mon_e.x + mon_e.gs);
                  chk("b2a_r1", o_r1, mon_e.gs);
`endif
               end
            end
         end
      end
      prev_v  = o_valid;
      prev_hs = o_valid && o_ready;
      prev_r0 = o_r0;
      prev_r1 = o_r1;
   end

   task automatic send(input logic op, input logic [W-1:0] x0, input logic [W-1:0] x1);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      @(posedge g_clk); #1;
      i_valid = 1'b1; i_op = op; i_x0 = x0; i_x1 = x1;
      for (int n = 0; n < 100; n++) begin
         @(negedge g_clk);
         if (i_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL accept_timeout actual=not_ready required=ready");
         i_valid = 1'b0;
         return;
      end
      e.op = op;
      e.gs = i_rnd[3*W-1:2*W];
      e.x  = op ? (x0 - x1) : (x0 ^ x1);
      @(posedge g_clk);
      e.t_acc = $time;
      sbq.push_back(e);
      #1 i_valid = 1'b0;
   endtask

   task automatic wait_done();
      for (int n = 0; n < 300; n++) begin
         @(negedge g_clk);
         if (sbq.size() == 0 && !o_valid) return;
      end
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", sbq.size());
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] rx0, rx1;
      bit seen;
      g_resetn = 1'b0; flush = 1'b0; i_valid = 1'b0; i_op = 1'b0;
      i_x0 = 32'h0; i_x1 = 32'h0; o_ready = 1'b1;
      repeat (2) @(posedge g_clk);
      @(negedge g_clk);
      chk("rst_valid", {31'h0, o_valid}, 32'h0);
      chk("rst_ready", {31'h0, i_ready}, 32'h0);
      chk("rst_r0", o_r0, 32'h0);
      chk("rst_r1", o_r1, 32'h0);
      chk("rst_op", {31'h0, o_op}, 32'h0);
      @(posedge g_clk); #1 g_resetn = 1'b1;
      mon_en = 1'b1;

      // B2A reference vector with fixed gs.
      gs_fix = 32'hA5A5A5A5; gs_fix_en = 1'b1;
      send(1'b0, 32'h12345678, 32'h0F0F0F0F);
      wait_done();
      gs_fix_en = 1'b0;

      // A2B 5 - 7, random then all-zero randomness; B2A with zero randomness.
      send(1'b1, 32'h00000005, 32'h00000007);
      wait_done();
      rnd_zero = 1'b1;
      send(1'b1, 32'h00000005, 32'h00000007);
      wait_done();
      send(1'b0, $urandom(), $urandom());
      wait_done();
      rnd_zero = 1'b0;

      // Backpressure: hold o_ready low for 3 cycles after o_valid.
      o_ready = 1'b0;
      send(1'b0, $urandom(), $urandom());
      seen = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge g_clk);
         if (o_valid) begin seen = 1'b1; break; end
      end
      chk("bp_valid_seen", {31'h0, seen}, 32'h1);
      repeat (3) @(posedge g_clk);
      #1 o_ready = 1'b1;
      wait_done();

      // Flush while in ROUND 2, then an immediate new request.
      send(1'b1, $urandom(), $urandom());
      repeat (3) @(posedge g_clk);
      #1 flush = 1'b1;
      @(posedge g_clk); #1 flush = 1'b0;
      void'(sbq.pop_back());
      @(negedge g_clk);
      chk("flush_ready", {31'h0, i_ready}, 32'h1);
      chk("flush_valid", {31'h0, o_valid}, 32'h0);
      send(1'b1, $urandom(), $urandom());
      wait_done();

      // Reset for one cycle while in INIT.
      send(1'b0, $urandom(), $urandom());
      g_resetn = 1'b0;
      @(posedge g_clk); #1 g_resetn = 1'b1;
      void'(sbq.pop_back());
      @(negedge g_clk);
      chk("midrst_valid", {31'h0, o_valid}, 32'h0);
      chk("midrst_ready", {31'h0, i_ready}, 32'h0);
      chk("midrst_r0", o_r0, 32'h0);
      send(1'b0, $urandom(), $urandom());
      wait_done();

      // Random requests with random backpressure and corner operands.
      rand_ordy = 1'b1;
      for (int i = 0; i < 25; i++) begin
         case ($urandom_range(0, 3))
            0: begin rx0 = $urandom(); rx1 = $urandom(); end
            1: begin rx0 = 32'h0; rx1 = 32'h0; end
            2: begin rx0 = 32'hFFFFFFFF; rx1 = $urandom(); end
            default: begin rx0 = $urandom(); rx1 = rx0; end
         endcase
         send(1'($urandom_range(0, 1)), rx0, rx1);
      end
      @(posedge g_clk);
      rand_ordy = 1'b0;
      #1 o_ready = 1'b1;
      wait_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
